freq_input_conditioner: RTL



---
 rtl/freq_input_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/freq_input_conditioner.sv
// Frequency-meter input front end: synchroniser, glitch filter, rising-edge pulse,
// optional decade prescaler (FREQ_COND_PRESCALE_EN) and no-signal idle monitor.
module freq_input_conditioner #(
    parameter int FILT_LEN    = 3,
    parameter int IDLE_W      = 26,
    parameter int IDLE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic [1:0] div_sel,
    output logic       edge_pulse,
    output logic       sig_filt,
    output logic       no_signal
);

    localparam logic [3:0]        FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(IDLE_CYCLES - 1);

    logic              s1_r;
    logic              s2_r;
    logic [3:0]        fcnt_r;
    logic              sig_filt_r;
    logic              filt_d_r;
    logic              edge_pulse_r;
    logic              no_signal_r;
    logic [IDLE_W-1:0] icnt_r;
    logic              raw_edge_s;
    logic              fire_s;

    assign raw_edge_s = sig_filt_r & ~filt_d_r;
    assign edge_pulse = edge_pulse_r;
    assign sig_filt   = sig_filt_r;
    assign no_signal  = no_signal_r;

    // Two-flop synchroniser for the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
        end
    end

    // Glitch filter: a level change must persist FILT_LEN consecutive cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r     <= 4'd0;
            sig_filt_r <= 1'b0;
            filt_d_r   <= 1'b0;
        end else begin
            filt_d_r <= sig_filt_r;
            if (s2_r == sig_filt_r) begin
                fcnt_r <= 4'd0;
            end else if (fcnt_r == FILT_MAX) begin
                sig_filt_r <= s2_r;
                fcnt_r     <= 4'd0;
            end else begin
                fcnt_r <= fcnt_r + 4'd1;
            end
        end
    end

`ifdef FREQ_COND_PRESCALE_EN
    logic [1:0] div_sel_r;
    logic [9:0] pcnt_r;
    logic [9:0] mod_max_s;
    logic       div_chg_s;

    assign div_chg_s = (div_sel_r != div_sel);
    assign fire_s    = raw_edge_s & ~div_chg_s & (pcnt_r == mod_max_s);

    // Terminal count of the decade prescaler for the registered select
    always_comb begin
        mod_max_s = 10'd0;
        case (div_sel_r)
            2'b00:   mod_max_s = 10'd0;
            2'b01:   mod_max_s = 10'd9;
            2'b10:   mod_max_s = 10'd99;
            2'b11:   mod_max_s = 10'd999;
            default: mod_max_s = 10'd0;
        endcase
    end

    // Prescaler count; a select change clears it and swallows a coincident edge
    always_ff @(posedge clk) begin
        if (rst) begin
            div_sel_r <= 2'b00;
            pcnt_r    <= 10'd0;
        end else begin
            div_sel_r <= div_sel;
            if (div_chg_s) begin
                pcnt_r <= 10'd0;
            end else if (raw_edge_s) begin
                if (pcnt_r == mod_max_s) begin
                    pcnt_r <= 10'd0;
                end else begin
                    pcnt_r <= pcnt_r + 10'd1;
                end
            end else begin
                pcnt_r <= pcnt_r;
            end
        end
    end
`else
    logic unused_div_sel_s;

    assign unused_div_sel_s = ^div_sel;
    assign fire_s           = raw_edge_s;
`endif

    // Registered count-enable pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_pulse_r <= 1'b0;
        end else begin
            edge_pulse_r <= fire_s;
        end
    end

    // Idle monitor on unprescaled edges; the counter saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_r      <= '0;
            no_signal_r <= 1'b1;
        end else if (raw_edge_s) begin
            icnt_r      <= '0;
            no_signal_r <= 1'b0;
        end else if (icnt_r == IDLE_PRE) begin
            icnt_r      <= IDLE_MAX;
            no_signal_r <= 1'b1;
        end else if (icnt_r != IDLE_MAX) begin
            icnt_r <= icnt_r + IDLE_W'(1);
        end else begin
            icnt_r <= icnt_r;
        end
    end

endmodule
